seven_segment_mux: RTL and testbench
====================================

Name: seven_segment_mux

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits that share one active-low segment bus.
- Each digit gets a fixed time slot. Its hex nibble is decoded to segments and its select line is asserted after a blanking gap, which prevents ghosting.
- Sits between datapath registers (packed nibbles) and the board display pins.
- Generalises the single-digit combinational hex decoder: adds digit count, refresh timing, per-digit blanking and tear-free value capture.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits; must be >= 1.
- DIGIT_CYCLES, 1024, clk cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits off; must satisfy 1 <= BLANK_CYCLES < DIGIT_CYCLES.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- values  input  4*NUM_DIGITS  packed hex nibbles; digit i = values[4*i+3:4*i].
- digit_enable  input  NUM_DIGITS  1 = digit i displayed; 0 = digit i blank during its slot.
- segments  output  7  {a,b,c,d,e,f,g}, a = MSB, active-low (0 = lit).
- digit_select  output  NUM_DIGITS  active-low digit enables; at most one bit low at any time.

Behaviour:
- Reset (synchronous, active-high): slot_cnt=0, digit_idx=0, latched nibble=0, latched enable=0, segments=7'b1111111, digit_select=all 1s.
- Reset asserted mid-slot forces this state on the next edge, regardless of phase.
- State:
  - slot_cnt counts 0..DIGIT_CYCLES-1, then wraps to 0.
  - On wrap, digit_idx increments; from NUM_DIGITS-1 it wraps to 0.
  - For NUM_DIGITS=1, digit_idx stays 0.
- Capture: on each edge where slot_cnt==0, latch values[digit_idx] and digit_enable[digit_idx]. Input changes mid-slot have no effect until that digit's next slot.
- Phase FSM, decoded from slot_cnt:
  - BLANK when slot_cnt < BLANK_CYCLES.
  - ON otherwise.
  - Sequence per slot: BLANK -> ON -> (slot end) BLANK for the next digit.
- Outputs are registered: the output value after edge t is a function of the state before edge t (one-cycle latency).
  - BLANK: segments=7'b1111111, digit_select=all 1s.
  - ON with latched enable=1: segments=decode(latched nibble); digit_select has only bit digit_idx low.
  - ON with latched enable=0: segments=7'b1111111, digit_select=all 1s.
- Resulting timing:
  - Each digit is lit for exactly DIGIT_CYCLES-BLANK_CYCLES cycles per slot.
  - The full refresh period is NUM_DIGITS*DIGIT_CYCLES.
  - Every change of digit_select is preceded by at least BLANK_CYCLES cycles of all-off.
- Decode table (active-low, abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Counter widths: $clog2 of the respective maximum. No counter overflow beyond the wrap points.

Optional Feature:
- Macro SEVEN_SEGMENT_MUX_DP_EN.
- Defined:
  - Adds input dp_in [NUM_DIGITS-1:0] and output dp (1 bit, active-low).
  - dp_in[digit_idx] is latched with the nibble at slot_cnt==0.
  - dp = ~latched_dp only in ON with latched enable=1; otherwise dp=1. Same registered timing as segments.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset, with NUM_DIGITS=2, DIGIT_CYCLES=8, BLANK_CYCLES=2: hold reset 3 cycles -> segments=7'b1111111, digit_select=2'b11.
- Timing, same parameters, values=8'h3A, digit_enable=2'b11, release reset:
  - Edges 1-2: blank.
  - Edges 3-8: digit_select=2'b10, segments=0001000 (A).
  - Edges 9-10: blank.
  - Edges 11-16: digit_select=2'b01, segments=0000110 (3).
  - Repeats with period 16.
- Tear-free capture: change values from 8'h3A to 8'hF1 at the 4th lit cycle of digit 0 -> digit 0 still shows A for the rest of its slot; digit 1 then shows F (0111000); digit 0 shows 1 (1001111) in its next slot.
- Blanking: digit_enable=2'b01 -> digit 1 slot has digit_select=2'b11 and segments=7'b1111111 throughout; digit 0 is unaffected.
- Reset mid-ON of digit 1 -> next edge gives all-off outputs; after release, sequence restarts at digit 0 exactly as in the timing scenario.
- Full sweep, NUM_DIGITS=4: walk all 16 nibbles on each digit and compare against the decode table. Assert at every cycle that no more than one digit_select bit is low. With SEVEN_SEGMENT_MUX_DP_EN: dp_in=4'b0100 -> dp=0 only during digit 2 ON cycles.

Source files
------------

// File: rtl/seven_segment_mux.sv
// seven_segment_mux
//   Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits
//   that share one active-low segment bus. Each digit owns a slot of
//   DIGIT_CYCLES clocks. The first BLANK_CYCLES of every slot keep all digits
//   dark to avoid ghosting. The digit's nibble and enable are captured at the
//   start of its slot, so input changes never tear a displayed digit.
//
// Ports
//   clk           system clock, all state on rising edge
//   reset         synchronous, active-high reset
//   values        packed hex nibbles, digit i = values[4*i+3:4*i]
//   digit_enable  1 = digit i shown during its slot, 0 = kept blank
//   segments      {a,b,c,d,e,f,g}, active-low, registered
//   digit_select  active-low digit enables, at most one low, registered
//   dp_in / dp    decimal point in (per digit) / out (active-low), present
//                 only when SEVEN_SEGMENT_MUX_DP_EN is defined
module seven_segment_mux #(
   parameter int NUM_DIGITS   = 2,
   parameter int DIGIT_CYCLES = 1024,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] values,
   input  logic [NUM_DIGITS-1:0]   digit_enable,
`ifdef SEVEN_SEGMENT_MUX_DP_EN
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic                    dp,
`endif
   output logic [6:0]              segments,
   output logic [NUM_DIGITS-1:0]   digit_select
);

   localparam int CNT_W = $clog2(DIGIT_CYCLES);
   // A single digit still needs a 1-bit index register.
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {PH_BLANK, PH_ON} phase_e;

   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0001100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

   logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
   logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
   logic [3:0]            nib_q, nib_d;
   logic                  en_q, en_d;
   logic [6:0]            segments_q, segments_d;
   logic [NUM_DIGITS-1:0] digit_select_q, digit_select_d;

   phase_e                phase;
   logic [3:0]            nib_sel;
   logic                  en_sel;
   logic [NUM_DIGITS-1:0] sel_onehot_n;

`ifdef SEVEN_SEGMENT_MUX_DP_EN
   logic dp_lat_q, dp_lat_d;
   logic dp_q, dp_d;
   logic dp_sel;
`endif

   always_comb begin
      phase        = (slot_cnt_q < BLANK_END) ? PH_BLANK : PH_ON;

      // Select the current digit's inputs and its active-low select pattern.
      nib_sel      = 4'h0;
      en_sel       = 1'b0;
      sel_onehot_n = '1;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
      dp_sel       = 1'b0;
`endif
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (digit_idx_q == IDX_W'(i)) begin
            nib_sel         = values[4*i +: 4];
            en_sel          = digit_enable[i];
            sel_onehot_n[i] = 1'b0;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
            dp_sel          = dp_in[i];
`endif
         end
      end

      slot_cnt_d  = (slot_cnt_q == LAST_SLOT) ? '0 : slot_cnt_q + CNT_W'(1);
      digit_idx_d = digit_idx_q;
      if (slot_cnt_q == LAST_SLOT)
         digit_idx_d = (digit_idx_q == LAST_IDX) ? '0 : digit_idx_q + IDX_W'(1);

      // Capture happens while the slot is still blank, so the new value can
      // never appear on a digit that is already lit.
      nib_d = nib_q;
      en_d  = en_q;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
      dp_lat_d = dp_lat_q;
`endif
      if (slot_cnt_q == '0) begin
         nib_d = nib_sel;
         en_d  = en_sel;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
         dp_lat_d = dp_sel;
`endif
      end

      segments_d     = 7'b1111111;
      digit_select_d = '1;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
      dp_d           = 1'b1;
`endif
      if (phase == PH_ON && en_q) begin
         segments_d     = hex_decode(nib_q);
         digit_select_d = sel_onehot_n;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
         dp_d           = ~dp_lat_q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt_q     <= '0;
         digit_idx_q    <= '0;
         nib_q          <= 4'h0;
         en_q           <= 1'b0;
         segments_q     <= 7'b1111111;
         digit_select_q <= '1;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
         dp_lat_q       <= 1'b0;
         dp_q           <= 1'b1;
`endif
      end else begin
         slot_cnt_q     <= slot_cnt_d;
         digit_idx_q    <= digit_idx_d;
         nib_q          <= nib_d;
         en_q           <= en_d;
         segments_q     <= segments_d;
         digit_select_q <= digit_select_d;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
         dp_lat_q       <= dp_lat_d;
         dp_q           <= dp_d;
`endif
      end
   end

   assign segments     = segments_q;
   assign digit_select = digit_select_q;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
   assign dp           = dp_q;
`endif

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux: a 2-digit instance (8-cycle slots,
// 2 blank cycles) for reset/timing/capture/blanking/mid-slot reset, and a
// 4-digit instance (4-cycle slots, 1 blank cycle) for the full decode sweep.
module tb_seven_segment_mux;

   logic       clk = 1'b0;
   logic       rst2, rst4;
   logic [7:0] values2;
   logic [1:0] en2;
   logic [6:0] seg2;
   logic [1:0] sel2;
   logic [15:0] values4;
   logic [3:0] en4;
   logic [6:0] seg4;
   logic [3:0] sel4;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
   logic [1:0] dp_in2;
   logic [3:0] dp_in4;
   logic       dp2, dp4;
`endif

   int n_checks = 0;
   int n_errs   = 0;
   logic mon_en = 1'b0;

   logic [6:0] seg_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   always #5 clk = ~clk;

   seven_segment_mux #(.NUM_DIGITS(2), .DIGIT_CYCLES(8), .BLANK_CYCLES(2)) u_dut2 (
      .clk(clk), .reset(rst2), .values(values2), .digit_enable(en2),
`ifdef SEVEN_SEGMENT_MUX_DP_EN
      .dp_in(dp_in2), .dp(dp2),
`endif
      .segments(seg2), .digit_select(sel2));

   seven_segment_mux #(.NUM_DIGITS(4), .DIGIT_CYCLES(4), .BLANK_CYCLES(1)) u_dut4 (
      .clk(clk), .reset(rst4), .values(values4), .digit_enable(en4),
`ifdef SEVEN_SEGMENT_MUX_DP_EN
      .dp_in(dp_in4), .dp(dp4),
`endif
      .segments(seg4), .digit_select(sel4));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance one edge of the 2-digit DUT; e is the 1-based edge within a
   // 16-edge refresh period.
   task automatic edge2(input int e, input logic [3:0] n0, input logic [3:0] n1,
                        input logic [1:0] en);
      int s, d;
      logic [6:0] es;
      logic [1:0] esel;
      step();
      s = (e - 1) % 8;
      d = (e - 1) / 8;
      es = 7'h7F;
      esel = 2'b11;
      if (s >= 2 && en[d]) begin
         es   = seg_tbl[(d == 1) ? n1 : n0];
         esel = (d == 1) ? 2'b01 : 2'b10;
      end
      check($sformatf("seg2 e%0d", e), 32'(seg2), 32'(es));
      check($sformatf("sel2 e%0d", e), 32'(sel2), 32'(esel));
`ifdef SEVEN_SEGMENT_MUX_DP_EN
      check($sformatf("dp2 e%0d", e), 32'(dp2), 32'd1);
`endif
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("onehot2", 32'($countones(~sel2) <= 1), 32'd1);
         check("onehot4", 32'($countones(~sel4) <= 1), 32'd1);
      end
   end

   initial begin
      rst2 = 1'b1; rst4 = 1'b1;
      values2 = 8'h3A; en2 = 2'b11;
      values4 = 16'h0; en4 = 4'hF;
`ifdef SEVEN_SEGMENT_MUX_DP_EN
      dp_in2 = 2'b00; dp_in4 = 4'b0100;
`endif
      // Reset held for three cycles
      for (int i = 0; i < 3; i++) step();
      mon_en = 1'b1;
      check("rst seg2", 32'(seg2), 32'h7F);
      check("rst sel2", 32'(sel2), 32'h3);
      check("rst seg4", 32'(seg4), 32'h7F);
      check("rst sel4", 32'(sel4), 32'hF);

      // Basic timing, two refresh periods
      rst2 = 1'b0;
      for (int p = 0; p < 2; p++)
         for (int e = 1; e <= 16; e++) edge2(e, 4'hA, 4'h3, 2'b11);

      // Change values after the 4th lit cycle of digit 0
      for (int e = 1; e <= 16; e++) begin
         edge2(e, 4'hA, 4'hF, 2'b11);
         if (e == 6) values2 = 8'hF1;
      end
      for (int e = 1; e <= 16; e++) edge2(e, 4'h1, 4'hF, 2'b11);

      // Digit 1 disabled
      en2 = 2'b01;
      for (int e = 1; e <= 16; e++) edge2(e, 4'h1, 4'hF, 2'b01);

      // Reset during digit 1 ON
      en2 = 2'b11;
      for (int e = 1; e <= 12; e++) edge2(e, 4'h1, 4'hF, 2'b11);
      rst2 = 1'b1;
      step();
      check("midrst seg2", 32'(seg2), 32'h7F);
      check("midrst sel2", 32'(sel2), 32'h3);
      rst2 = 1'b0;
      values2 = 8'h3A;
      for (int e = 1; e <= 16; e++) edge2(e, 4'hA, 4'h3, 2'b11);
      rst2 = 1'b1;

      // Full decode sweep on the 4-digit instance
      rst4 = 1'b0;
      for (int m = 0; m < 16; m++) begin
         for (int d = 0; d < 4; d++) values4[4*d +: 4] = 4'((m + d) % 16);
         for (int e = 1; e <= 16; e++) begin
            int s, d;
            logic [6:0] es;
            logic [3:0] esel;
            logic       edp;
            step();
            s = (e - 1) % 4;
            d = (e - 1) / 4;
            es = 7'h7F; esel = 4'hF; edp = 1'b1;
            if (s >= 1) begin
               es = seg_tbl[(m + d) % 16];
               esel[d] = 1'b0;
               edp = (d == 2) ? 1'b0 : 1'b1;
            end
            check($sformatf("seg4 m%0d e%0d", m, e), 32'(seg4), 32'(es));
            check($sformatf("sel4 m%0d e%0d", m, e), 32'(sel4), 32'(esel));
`ifdef SEVEN_SEGMENT_MUX_DP_EN
            check($sformatf("dp4 m%0d e%0d", m, e), 32'(dp4), 32'(edp));
`else
            if (edp == 1'b0) ;
`endif
         end
      end

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
